// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle control unit: ALU controls, ALU-op classes,
// opcodes, immediate formats and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ, S_ILLEGAL
  } state_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// master = controller side, slave = datapath / instruction-register side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] ALUControl;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU decoder: maps ALU-op class plus funct fields to ALUControl,
// and flags funct combinations the ALU does not implement.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  alu_op_t    alu_op,
  output logic [3:0] alu_control,
  output logic       illegal
);

  logic [3:0] funct_ctl;
  logic       f7_ok;

  // I-type funct7 bits are immediate bits, so only R-type must match funct7 exactly.
  assign f7_ok = !op5 || (funct7 == F7_ZERO);

  always_comb begin
    funct_ctl = ALU_ADD;
    illegal   = 1'b0;
    case (funct3)
      3'b000: begin
        if (op5 && funct7 == F7_SUB)         funct_ctl = ALU_SUB;
        else if (op5 && funct7 == F7_MULDIV) funct_ctl = ALU_MUL;
        else if (f7_ok)                      funct_ctl = ALU_ADD;
        else                                 illegal   = 1'b1;
      end
      3'b001: if (f7_ok) funct_ctl = ALU_SLL; else illegal = 1'b1;
      3'b100: if (op5 && funct7 == F7_MULDIV) funct_ctl = ALU_DIV; else illegal = 1'b1;
      3'b101: if (funct7 == F7_ZERO) funct_ctl = ALU_SRL; else illegal = 1'b1;
      3'b110: if (f7_ok) funct_ctl = ALU_OR;  else illegal = 1'b1;
      3'b111: if (f7_ok) funct_ctl = ALU_AND; else illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctl;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: Moore sequencer stepping each instruction through its
// states, with ALUControl supplied by alu_ctrl_dec.
module multicycle_ctrl
  import alu_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  multicycle_ctrl_if.master         bus,
  output state_t                    state_dbg
);

  state_t     state, state_nx;
  alu_op_t    alu_op;
  logic [3:0] alu_control;
  logic       dec_illegal;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;

  alu_ctrl_dec u_dec (
    .op5         (bus.op[5]),
    .funct3      (bus.funct3),
    .funct7      (bus.funct7),
    .alu_op      (alu_op),
    .alu_control (alu_control),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = dec_illegal ? S_ILLEGAL : S_EXECR;
          OP_I:         state_nx = dec_illegal ? S_ILLEGAL : S_EXECI;
          OP_JAL:       state_nx = S_JAL;
          OP_BEQ:       state_nx = S_BEQ;
          default:      state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_nx = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_nx = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_nx = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_nx = S_FETCH;
      S_ILLEGAL: state_nx = S_ILLEGAL;
      default:   state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write = 1'b1; pc_write = 1'b1;
        alu_src_b = 2'b10; result_src = 2'b10;
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      S_EXECR:    begin alu_src_a = 2'b10; alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
      // Branch decision is the one Mealy term: Zero comes straight from the comparator.
      S_BEQ:      begin alu_src_a = 2'b10; alu_op = ALUOP_SUB; pc_write = bus.Zero; end
      default:    ;
    endcase
  end

  // Enables are masked by reset so nothing partial escapes while it is asserted.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.Illegal    = (state == S_ILLEGAL) & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src_of(bus.op);
  assign bus.ALUControl = alu_control;
  assign state_dbg      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected control words queued by the driver,
// popped and compared by a negedge monitor.
module tb_multicycle_ctrl;
  import alu_pkg::*;

  localparam int W = 18;

  typedef enum logic [3:0] {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_ILL, P_RST
  } phase_t;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;
  logic [W-1:0] exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     slot_no  = 0;
  int     zero_force = -1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Returns the ALU operation for an R (r=1) or I (r=0) instruction, bad=1 if unsupported.
  function automatic logic [3:0] ref_alu(input logic r, input logic [2:0] f3,
                                         input logic [6:0] f7, output logic bad);
    bad = 1'b0;
    if (r) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: return 4'b0000;
          3'd1: return 4'b1000;
          3'd5: return 4'b0111;
          3'd6: return 4'b0011;
          3'd7: return 4'b0010;
          default: begin bad = 1'b1; return 4'b0000; end
        endcase
      end
      if (f7 == 7'h20 && f3 == 3'd0) return 4'b0001;
      if (f7 == 7'h01 && f3 == 3'd0) return 4'b1001;
      if (f7 == 7'h01 && f3 == 3'd4) return 4'b0100;
      bad = 1'b1;
      return 4'b0000;
    end
    case (f3)
      3'd0: return 4'b0000;
      3'd1: return 4'b1000;
      3'd5: begin
        if (f7 == 7'h00) return 4'b0111;
        bad = 1'b1;
        return 4'b0000;
      end
      3'd6: return 4'b0011;
      3'd7: return 4'b0010;
      default: begin bad = 1'b1; return 4'b0000; end
    endcase
  endfunction

  function automatic logic [W-1:0] mk(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] imm, input logic rw,
                                      input logic [3:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill};
  endfunction

  function automatic logic [W-1:0] exp_of(input phase_t p, input logic [1:0] imm,
                                          input logic [3:0] alu, input logic z);
    case (p)
      P_FETCH:    return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, imm, 1'b0, 4'b0000, 1'b0);
      P_DECODE:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0, 4'b0000, 1'b0);
      P_MEMADR:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, 4'b0000, 1'b0);
      P_MEMREAD:  return mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 4'b0000, 1'b0);
      P_MEMWB:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, imm, 1'b1, 4'b0000, 1'b0);
      P_MEMWRITE: return mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 4'b0000, 1'b0);
      P_EXECR:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0, alu,     1'b0);
      P_EXECI:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, alu,     1'b0);
      P_ALUWB:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b1, 4'b0000, 1'b0);
      P_JAL:      return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 1'b0, 4'b0000, 1'b0);
      P_BEQ:      return mk(z,    1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0, 4'b0001, 1'b0);
      P_ILL:      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 4'b0000, 1'b1);
      default:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 1'b0, 4'b0000, 1'b0);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // One slot = one clock cycle, starting 1 time unit after a rising edge.
  task automatic do_slot(input phase_t p, input logic [1:0] imm, input logic [3:0] alu);
    logic z;
    z = (zero_force >= 0) ? zero_force[0] : 1'($urandom_range(0, 1));
    bus.Zero = z;
    exp_q.push_back(exp_of(p, imm, alu, z));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [1:0] imm;
    logic [3:0] alu;
    logic       bad;
    bus.op = op; bus.funct3 = f3; bus.funct7 = f7;
    imm = ref_imm(op);
    alu = ref_alu(op[5], f3, f7, bad);
    do_slot(P_FETCH, imm, alu);
    do_slot(P_DECODE, imm, alu);
    if (op == 7'b0000011) begin
      do_slot(P_MEMADR, imm, alu); do_slot(P_MEMREAD, imm, alu); do_slot(P_MEMWB, imm, alu);
    end else if (op == 7'b0100011) begin
      do_slot(P_MEMADR, imm, alu); do_slot(P_MEMWRITE, imm, alu);
    end else if (op == 7'b0110011 && !bad) begin
      do_slot(P_EXECR, imm, alu); do_slot(P_ALUWB, imm, alu);
    end else if (op == 7'b0010011 && !bad) begin
      do_slot(P_EXECI, imm, alu); do_slot(P_ALUWB, imm, alu);
    end else if (op == 7'b1101111) begin
      do_slot(P_JAL, imm, alu); do_slot(P_ALUWB, imm, alu);
    end else if (op == 7'b1100011) begin
      do_slot(P_BEQ, imm, alu);
    end else begin
      repeat (3) do_slot(P_ILL, imm, alu);
      reset = 1'b1;
      repeat (2) do_slot(P_RST, imm, alu);
      reset = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // sw interrupted by reset while in its memory-write cycle.
  task automatic sw_with_reset();
    logic [1:0] imm;
    imm = ref_imm(7'b0100011);
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7 = 7'h11;
    do_slot(P_FETCH, imm, 4'b0000);
    do_slot(P_DECODE, imm, 4'b0000);
    do_slot(P_MEMADR, imm, 4'b0000);
    check("memwrite_before_reset", 32'(bus.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("memwrite_on_reset", 32'(bus.MemWrite), 32'd0);
    check("state_on_reset", 32'(state_dbg), 32'(S_FETCH));
    repeat (3) do_slot(P_RST, imm, 4'b0000);
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl, bus.Illegal};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL ctl_word slot=%0d actual=%h required=%h", slot_no, act, e);
      end
      slot_no++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] f7_set [4];
    logic [2:0] f3_i   [5];
    logic [6:0] f7;
    logic [2:0] f3;
    f7_set = '{7'h00, 7'h20, 7'h01, 7'h00};
    f3_i   = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
    reset = 1'b1;
    bus.op = 7'b0000011; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.Zero = 1'b0;
    @(posedge clk); #1;
    check("reset_state", 32'(state_dbg), 32'(S_FETCH));
    check("reset_illegal", 32'(bus.Illegal), 32'd0);
    repeat (2) do_slot(P_RST, 2'b00, 4'b0000);
    reset = 1'b0;

    // directed
    run_instr(7'b0110011, 3'd0, 7'h00);   // add
    run_instr(7'b0110011, 3'd0, 7'h20);   // sub
    run_instr(7'b0110011, 3'd0, 7'h01);   // mul
    run_instr(7'b0110011, 3'd4, 7'h01);   // div
    run_instr(7'b0000011, 3'd2, 7'h05);   // lw
    run_instr(7'b0100011, 3'd2, 7'h7f);   // sw
    zero_force = 1; run_instr(7'b1100011, 3'd0, 7'h00);
    zero_force = 0; run_instr(7'b1100011, 3'd0, 7'h00);
    zero_force = -1;
    run_instr(7'b1101111, 3'd3, 7'h2a);   // jal
    run_instr(7'b0010011, 3'd5, 7'h00);   // srli
    run_instr(7'b0000000, 3'd0, 7'h00);   // unknown opcode
    run_instr(7'b0110011, 3'd4, 7'h00);   // xor -> illegal
    sw_with_reset();
    run_instr(7'b0110011, 3'd7, 7'h00);   // and, first after reset

    // randomized
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: run_instr(7'b0000011, 3'($urandom), 7'($urandom));
        1: run_instr(7'b0100011, 3'($urandom), 7'($urandom));
        2: run_instr(7'b1101111, 3'($urandom), 7'($urandom));
        3: run_instr(7'b1100011, 3'($urandom), 7'($urandom));
        4, 5: begin
          f3 = f3_i[$urandom_range(0, 4)];
          run_instr(7'b0110011, f3, 7'h00);
        end
        6: begin
          f3 = f3_i[$urandom_range(0, 4)];
          f7 = (f3 == 3'd5) ? 7'h00 : 7'($urandom);
          run_instr(7'b0010011, f3, f7);
        end
        7: begin
          f7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7_set[$urandom_range(0, 3)];
          run_instr(7'b0110011, 3'($urandom), f7);
        end
        8: run_instr(7'($urandom), 3'($urandom), 7'($urandom));
        default: run_instr(7'b0010011, 3'($urandom), 7'($urandom));
      endcase
    end

    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
